// File: rtl/pll_cfg_master.sv
// PLL dynamic-configuration port initiator: strobe/ack register access,
// masked read-modify-write, and a reset-and-relock apply sequence.
module pll_cfg_master #(
    parameter int ACK_TIMEOUT  = 64,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_CNT_W   = 16
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [4:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    input  logic [7:0] cmd_mask,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       pll_stb,
    output logic       pll_we,
    output logic [4:0] pll_addr,
    output logic [7:0] pll_dati,
    input  logic       pll_ack,
    input  logic [7:0] pll_dato,
    output logic       pll_rst,
    input  logic       pll_lock,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, RD_STB, WR_STB, GAP, RSP, APPLY_RST, WAIT_LOCK
    } state_t;

    localparam logic [1:0] OP_RMW = 2'b10;
    localparam logic [LOCK_CNT_W-1:0] ACK_LAST  = LOCK_CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [LOCK_CNT_W-1:0] RST_LAST  = LOCK_CNT_W'(RST_CYCLES - 1);
    localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_TIMEOUT - 1);

    state_t                state_q;
    logic [1:0]            op_q;
    logic [7:0]            wdata_q;
    logic [7:0]            mask_q;
    logic [7:0]            rdata_q;
    logic [LOCK_CNT_W-1:0] cnt_q;
    logic                  lock_meta_q;
    logic                  lock_sync_q;
    logic                  rsp_valid_q;
    logic [7:0]            rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  stb_q;
    logic                  we_q;
    logic [4:0]            addr_q;
    logic [7:0]            dati_q;
    logic                  rst_q;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            op_q        <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            dati_q      <= '0;
            rst_q       <= 1'b0;
        end else begin
            // Lock seen while the PLL is held in reset is stale; flush it.
            lock_meta_q <= rst_q ? 1'b0 : pll_lock;
            lock_sync_q <= rst_q ? 1'b0 : lock_meta_q;
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        wdata_q <= cmd_wdata;
                        mask_q  <= cmd_mask;
                        rdata_q <= '0;
                        cnt_q   <= '0;
                        addr_q  <= cmd_addr;
                        unique case (cmd_op)
                            2'b00, 2'b10: begin
                                stb_q   <= 1'b1;
                                we_q    <= 1'b0;
                                state_q <= RD_STB;
                            end
                            2'b01: begin
                                stb_q   <= 1'b1;
                                we_q    <= 1'b1;
                                dati_q  <= cmd_wdata;
                                state_q <= WR_STB;
                            end
                            default: begin
                                rst_q   <= 1'b1;
                                state_q <= APPLY_RST;
                            end
                        endcase
                    end
                end
                RD_STB: begin
                    if (pll_ack) begin
                        stb_q   <= 1'b0;
                        rdata_q <= pll_dato;
                        cnt_q   <= '0;
                        if (op_q == OP_RMW) begin
                            state_q <= GAP;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= pll_dato;
                            rsp_err_q   <= 1'b0;
                            state_q     <= RSP;
                        end
                    end else if (cnt_q == ACK_LAST) begin
                        stb_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= RSP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    stb_q   <= 1'b1;
                    we_q    <= 1'b1;
                    dati_q  <= (rdata_q & ~mask_q) | (wdata_q & mask_q);
                    cnt_q   <= '0;
                    state_q <= WR_STB;
                end
                WR_STB: begin
                    if (pll_ack || cnt_q == ACK_LAST) begin
                        stb_q       <= 1'b0;
                        we_q        <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata_q;
                        rsp_err_q   <= !pll_ack;
                        state_q     <= RSP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                APPLY_RST: begin
                    if (cnt_q == RST_LAST) begin
                        rst_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= WAIT_LOCK;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_sync_q || cnt_q == LOCK_LAST) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= !lock_sync_q;
                        state_q     <= RSP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RSP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign pll_stb   = stb_q;
    assign pll_we    = we_q;
    assign pll_addr  = addr_q;
    assign pll_dati  = dati_q;
    assign pll_rst   = rst_q;

endmodule

// File: tb/tb_pll_cfg_master.sv
// Directed bench for pll_cfg_master with a strobe/ack PLL responder model.
module tb_pll_cfg_master;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [4:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic [7:0] cmd_mask = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       pll_stb;
    logic       pll_we;
    logic [4:0] pll_addr;
    logic [7:0] pll_dati;
    logic       pll_ack = 1'b0;
    logic [7:0] pll_dato = '0;
    logic       pll_rst;
    logic       pll_lock = 1'b0;
    logic       busy;

    int n = 0;
    int f = 0;

    pll_cfg_master dut (
        .CLK(clk), .RSTN(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .pll_stb(pll_stb), .pll_we(pll_we),
        .pll_addr(pll_addr), .pll_dati(pll_dati),
        .pll_ack(pll_ack), .pll_dato(pll_dato),
        .pll_rst(pll_rst), .pll_lock(pll_lock), .busy(busy)
    );

    always #5 clk = ~clk;

    // Responder model and monitor, both evaluated on the falling edge.
    bit       ack_en = 1'b1;
    int       ack_delay = 1;
    logic [7:0] rd_val = '0;
    int       stb_age = 0;
    logic [7:0] ack_dati;
    logic       ack_we;
    logic [4:0] ack_addr;
    int cyc = 0, stb_hi = 0, stb_rises = 0, wr_rises = 0;
    int low_run = 0, last_gap = -1, rst_hi = 0, rsp_pulses = 0;
    int fall_cyc = 0, rsp_cyc = 0;
    bit unstable = 1'b0;
    logic       prev_stb = 1'b0, prev_we = 1'b0, prev_rst = 1'b0;
    logic [7:0] prev_dati = '0;
    logic [4:0] prev_addr = '0;

    always @(negedge clk) begin
        cyc++;
        if (pll_stb === 1'b1) begin
            if (prev_stb !== 1'b1) begin
                stb_rises++;
                if (pll_we === 1'b1) wr_rises++;
                if (stb_rises > 1) last_gap = low_run;
            end else if (pll_dati !== prev_dati || pll_addr !== prev_addr
                         || pll_we !== prev_we) begin
                unstable = 1'b1;
            end
            stb_hi++;
            low_run = 0;
        end else begin
            low_run++;
        end
        if (pll_rst === 1'b1) rst_hi++;
        if (prev_rst === 1'b1 && pll_rst === 1'b0) fall_cyc = cyc;
        if (rsp_valid === 1'b1) begin
            rsp_pulses++;
            rsp_cyc = cyc;
        end
        prev_stb  = pll_stb;
        prev_we   = pll_we;
        prev_rst  = pll_rst;
        prev_dati = pll_dati;
        prev_addr = pll_addr;
        if (pll_stb === 1'b1) begin
            stb_age++;
            if (ack_en && stb_age == ack_delay) begin
                pll_ack  = 1'b1;
                pll_dato = rd_val;
                ack_dati = pll_dati;
                ack_we   = pll_we;
                ack_addr = pll_addr;
            end else begin
                pll_ack = 1'b0;
            end
        end else begin
            stb_age = 0;
            pll_ack = 1'b0;
        end
    end

    task automatic clr_mon();
        stb_hi = 0; stb_rises = 0; wr_rises = 0; last_gap = -1;
        rst_hi = 0; rsp_pulses = 0; unstable = 1'b0;
        ack_dati = 'x; ack_we = 1'bx; ack_addr = 'x;
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] a,
                         input logic [7:0] wd, input logic [7:0] m,
                         input int limit, output bit got);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a;
        cmd_wdata = wd; cmd_mask = m;
        @(negedge clk);
        cmd_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            if (rsp_valid === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n++; if (cmd_ready !== 1'b1) begin f++; $display("FAIL rst_ready got %b want 1", cmd_ready); end
        n++; if ({busy, rsp_valid, rsp_err, pll_stb, pll_we, pll_rst} !== 6'b0) begin
            f++; $display("FAIL rst_ctl got %b want 000000",
                          {busy, rsp_valid, rsp_err, pll_stb, pll_we, pll_rst});
        end
        n++; if ({rsp_rdata, pll_addr, pll_dati} !== 21'h0) begin
            f++; $display("FAIL rst_data got %h want 0", {rsp_rdata, pll_addr, pll_dati});
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        bit got;
        clr_mon(); ack_en = 1'b1; ack_delay = 3; rd_val = 8'h5C;
        issue(2'b00, 5'h0A, 8'h00, 8'h00, 200, got);
        n++; if (!got) begin f++; $display("FAIL rd_rsp got none want rsp_valid"); end
        n++; if (rsp_rdata !== 8'h5C) begin f++; $display("FAIL rd_data got %h want 5c", rsp_rdata); end
        n++; if (rsp_err !== 1'b0) begin f++; $display("FAIL rd_err got %b want 0", rsp_err); end
        n++; if (stb_hi != 3) begin f++; $display("FAIL rd_stb_len got %0d want 3", stb_hi); end
        n++; if (ack_addr !== 5'h0A || ack_we !== 1'b0) begin
            f++; $display("FAIL rd_addr got %h/%b want 0a/0", ack_addr, ack_we);
        end
        @(negedge clk); #1;
        n++; if (rsp_valid !== 1'b0 || rsp_pulses != 1) begin
            f++; $display("FAIL rd_pulse got %b/%0d want 0/1", rsp_valid, rsp_pulses);
        end
        n++; if (rsp_rdata !== 8'h5C) begin f++; $display("FAIL rd_hold got %h want 5c", rsp_rdata); end
    endtask

    task automatic test_write();
        bit got;
        clr_mon(); ack_en = 1'b1; ack_delay = 1;
        issue(2'b01, 5'h03, 8'h09, 8'h00, 200, got);
        n++; if (!got) begin f++; $display("FAIL wr_rsp got none want rsp_valid"); end
        n++; if (ack_we !== 1'b1 || ack_dati !== 8'h09 || ack_addr !== 5'h03) begin
            f++; $display("FAIL wr_bus got %b/%h/%h want 1/09/03", ack_we, ack_dati, ack_addr);
        end
        n++; if (rsp_err !== 1'b0 || rsp_rdata !== 8'h00) begin
            f++; $display("FAIL wr_rsp_val got %b/%h want 0/00", rsp_err, rsp_rdata);
        end
        n++; if (stb_hi != 1) begin f++; $display("FAIL wr_stb_len got %0d want 1", stb_hi); end
        @(negedge clk); #1;
        n++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            f++; $display("FAIL wr_ready got %b/%b want 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_rmw();
        bit got;
        clr_mon(); ack_en = 1'b1; ack_delay = 2; rd_val = 8'hF0;
        issue(2'b10, 5'h05, 8'h0A, 8'h0F, 200, got);
        n++; if (!got) begin f++; $display("FAIL rmw_rsp got none want rsp_valid"); end
        n++; if (rsp_rdata !== 8'hF0 || rsp_err !== 1'b0) begin
            f++; $display("FAIL rmw_rsp_val got %h/%b want f0/0", rsp_rdata, rsp_err);
        end
        n++; if (stb_rises != 2 || wr_rises != 1) begin
            f++; $display("FAIL rmw_strobes got %0d/%0d want 2/1", stb_rises, wr_rises);
        end
        n++; if (last_gap != 1) begin f++; $display("FAIL rmw_gap got %0d want 1", last_gap); end
        n++; if (ack_dati !== 8'hFA || ack_addr !== 5'h05) begin
            f++; $display("FAIL rmw_wdata got %h/%h want fa/05", ack_dati, ack_addr);
        end
        n++; if (unstable) begin f++; $display("FAIL rmw_stable got unstable want stable"); end
        @(negedge clk);
    endtask

    task automatic test_ack_timeout();
        bit got;
        clr_mon(); ack_en = 1'b0;
        issue(2'b00, 5'h11, 8'h00, 8'h00, 300, got);
        n++; if (!got) begin f++; $display("FAIL to_rsp got none want rsp_valid"); end
        n++; if (stb_hi != 64) begin f++; $display("FAIL to_stb_len got %0d want 64", stb_hi); end
        n++; if (rsp_err !== 1'b1) begin f++; $display("FAIL to_err got %b want 1", rsp_err); end
        @(negedge clk);
        clr_mon();
        issue(2'b10, 5'h12, 8'h55, 8'hFF, 300, got);
        n++; if (!got || rsp_err !== 1'b1) begin
            f++; $display("FAIL to_rmw_err got %b/%b want 1/1", got, rsp_err);
        end
        n++; if (stb_rises != 1 || wr_rises != 0) begin
            f++; $display("FAIL to_rmw_nowr got %0d/%0d want 1/0", stb_rises, wr_rises);
        end
        @(negedge clk);
        ack_en = 1'b1;
    endtask

    task automatic test_apply();
        bit got;
        clr_mon(); pll_lock = 1'b0;
        fork
            issue(2'b11, 5'h00, 8'h00, 8'h00, 2000, got);
            begin
                for (int i = 0; i < 100 && pll_rst !== 1'b1; i++) @(negedge clk);
                for (int i = 0; i < 100 && pll_rst !== 1'b0; i++) @(negedge clk);
                repeat (200) @(negedge clk);
                pll_lock = 1'b1;
            end
        join
        n++; if (!got || rsp_err !== 1'b0) begin
            f++; $display("FAIL ap_ok got %b/%b want 1/0", got, rsp_err);
        end
        n++; if (rst_hi != 16) begin f++; $display("FAIL ap_rst_len got %0d want 16", rst_hi); end
        n++; if (rsp_cyc - fall_cyc < 201 || rsp_cyc - fall_cyc > 205) begin
            f++; $display("FAIL ap_lock_lat got %0d want 201..205", rsp_cyc - fall_cyc);
        end
        n++; if (rsp_rdata !== 8'h00) begin f++; $display("FAIL ap_rdata got %h want 00", rsp_rdata); end
        @(negedge clk);
        pll_lock = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_apply_timeout();
        bit got;
        clr_mon(); pll_lock = 1'b0;
        issue(2'b11, 5'h00, 8'h00, 8'h00, 70000, got);
        n++; if (!got || rsp_err !== 1'b1) begin
            f++; $display("FAIL ap_to got %b/%b want 1/1", got, rsp_err);
        end
        n++; if (rsp_cyc - fall_cyc != 65535) begin
            f++; $display("FAIL ap_to_len got %0d want 65535", rsp_cyc - fall_cyc);
        end
        n++; if (rst_hi != 16) begin f++; $display("FAIL ap_to_rst got %0d want 16", rst_hi); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        bit got;
        clr_mon(); ack_en = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 5'h07; cmd_wdata = 8'h3C;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        n++; if (pll_stb !== 1'b1) begin f++; $display("FAIL mid_stb got %b want 1", pll_stb); end
        rstn = 1'b0;
        @(negedge clk); #1;
        n++; if ({pll_stb, pll_we, busy, rsp_valid, pll_rst} !== 5'b0 || cmd_ready !== 1'b1) begin
            f++; $display("FAIL mid_rst got %b/%b want 00000/1",
                          {pll_stb, pll_we, busy, rsp_valid, pll_rst}, cmd_ready);
        end
        n++; if ({pll_addr, pll_dati} !== 13'h0) begin
            f++; $display("FAIL mid_bus got %h want 0", {pll_addr, pll_dati});
        end
        rstn = 1'b1;
        repeat (3) @(negedge clk); #1;
        n++; if (rsp_pulses != 0) begin f++; $display("FAIL mid_norsp got %0d want 0", rsp_pulses); end
        ack_en = 1'b1; ack_delay = 1; clr_mon();
        issue(2'b01, 5'h1F, 8'hA5, 8'h00, 200, got);
        n++; if (!got || rsp_err !== 1'b0 || ack_dati !== 8'hA5) begin
            f++; $display("FAIL mid_after got %b/%b/%h want 1/0/a5", got, rsp_err, ack_dati);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_rmw();
        test_ack_timeout();
        test_apply();
        test_apply_timeout();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", n, f);
        $finish;
    end

endmodule

// File: doc/pll_cfg_master.md
Name: pll_cfg_master

Overview:
Initiator for the PLL dynamic configuration port (PLLSTB/PLLWE/PLLADDR/PLLDATI/PLLACK/PLLDATO). It accepts register commands from the system control bus and runs the strobe/ack transactions, including masked read-modify-write. An optional apply sequence pulses PLL reset and waits for LOCK, so the CLKOP/CLKOS dividers can be retuned at runtime. It runs on the PLL config clock (PLLCLK domain) and drives the PLL wrapper's config pins directly.

Parameters:
ACK_TIMEOUT, 64, max cycles to wait for PLLACK after strobe (>=2)
RST_CYCLES, 16, PLL reset pulse width in cycles (>=1)
LOCK_TIMEOUT, 65535, max cycles to wait for LOCK after reset release
LOCK_CNT_W, 16, width of lock/timeout counter (must hold LOCK_TIMEOUT)

Ports:
CLK  in  1  config clock, also driven to PLLCLK
RSTN  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept command (high only in IDLE)
cmd_op  in  2  00 read, 01 write, 10 RMW, 11 apply (reset+lock)
cmd_addr  in  5  register address
cmd_wdata  in  8  write data
cmd_mask  in  8  RMW bit mask, 1 = take bit from cmd_wdata
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  8  read data (read/RMW: value read before modify)
rsp_err  out  1  timeout occurred, qualified by rsp_valid
pll_stb  out  1  to PLLSTB
pll_we  out  1  to PLLWE
pll_addr  out  5  to PLLADDR[4:0]
pll_dati  out  8  to PLLDATI[7:0]
pll_ack  in  1  from PLLACK
pll_dato  in  8  from PLLDATO[7:0]
pll_rst  out  1  to PLL RST, active high
pll_lock  in  1  from LOCK (asynchronous; double-flopped internally)
busy  out  1  high whenever not IDLE

Behaviour:
- Reset (RSTN=0 at rising CLK): state IDLE; cmd_ready=1 after reset released; rsp_valid=0, rsp_rdata=0, rsp_err=0, pll_stb=0, pll_we=0, pll_addr=0, pll_dati=0, pll_rst=0, busy=0; counters and lock synchroniser cleared. Reset mid-transaction aborts immediately; no response issued.
- Command accepted on cmd_valid & cmd_ready; addr/wdata/mask/op captured; next cycle leaves IDLE. cmd_ready low until return to IDLE.
- States: IDLE, RD_STB, WR_STB, GAP, RSP, APPLY_RST, WAIT_LOCK.
- Read: RD_STB drives pll_stb=1, pll_we=0, pll_addr held stable until pll_ack sampled high; rdata <= pll_dato on that ack cycle; pll_stb drops the following cycle -> RSP.
- Write: WR_STB drives pll_stb=1, pll_we=1, pll_addr, pll_dati stable until ack -> RSP.
- RMW: RD_STB, then GAP (exactly one cycle pll_stb=0), then WR_STB with pll_dati = (rd & ~mask) | (wdata & mask); rsp_rdata = the read value.
- Strobe never stays high more than one cycle after ack; back-to-back strobes always separated by >=1 low cycle.
- Ack timeout: counter starts at strobe assertion; if ACK_TIMEOUT cycles elapse without ack, drop strobe -> RSP with rsp_err=1; RMW aborts without write. Ack outside a strobe is ignored.
- Apply: APPLY_RST holds pll_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK; RSP when synchronised lock=1 (rsp_err=0) or after LOCK_TIMEOUT cycles (rsp_err=1). Lock already high during reset pulse is disregarded.
- RSP: rsp_valid=1 for one cycle with rsp_rdata/rsp_err; rsp_rdata holds until next response; next cycle IDLE. Write/apply responses report rsp_rdata=0.
- cmd inputs ignored while busy; no queuing.

Test Plan:
- Read addr 0x0A, PLL model acks after 3 cycles with dato 0x5C -> stb high 3 cycles, rsp_valid one pulse, rsp_rdata=0x5C, rsp_err=0.
- Write addr 0x03 data 0x09, ack after 1 cycle -> pll_we=1, pll_dati=0x09 stable through ack, rsp_err=0, cmd_ready back high next cycle.
- RMW addr 0x05, read returns 0xF0, wdata 0x0A, mask 0x0F -> exactly one stb-low gap, written 0xFA, rsp_rdata=0xF0.
- No ack, ACK_TIMEOUT=64 -> stb drops after 64 cycles, rsp_err=1; RMW variant issues no write strobe.
- Apply, lock rises 200 cycles after release -> pll_rst high exactly 16 cycles, rsp_err=0; lock held low -> rsp_err=1 after 65535 cycles.
- RSTN low mid-write with stb high -> all outputs to reset values next edge, no rsp_valid; new command then completes normally.
